// File: rtl/writeback_regfile.sv
// Write-back stage and 32x32 register file: result select, commit, async reads, late-forward copy, commit counter.
// Optional REGFILE_BYPASS_EN makes the read ports write-through (same-cycle write visible to decode).
module writeback_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MW_MemtoReg,
    input  logic              MW_RegWrite,
    input  logic [DATA_W-1:0] MW_ALUout,
    input  logic [DATA_W-1:0] MDR,
    input  logic [ADDR_W-1:0] MW_RD,
    input  logic [ADDR_W-1:0] RS_addr,
    input  logic [ADDR_W-1:0] RT_addr,
    output logic [DATA_W-1:0] RS_data,
    output logic [DATA_W-1:0] RT_data,
    output logic [DATA_W-1:0] WB_data,
    output logic              WB_we,
    output logic              WBL_RegWrite,
    output logic [ADDR_W-1:0] WBL_RD,
    output logic [DATA_W-1:0] WBL_data,
    output logic [CNT_W-1:0]  wb_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs [0:DEPTH-1];

    assign WB_data = MW_MemtoReg ? MDR : MW_ALUout;
    // Writes to R0 are dropped here, so R0 never leaves its reset value.
    assign WB_we   = MW_RegWrite && (MW_RD != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (WB_we) begin
            regs[MW_RD] <= WB_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_count     <= '0;
            WBL_RegWrite <= 1'b0;
            WBL_RD       <= '0;
            WBL_data     <= '0;
        end else begin
            if (WB_we && (wb_count != CNT_MAX)) begin
                wb_count <= wb_count + CNT_ONE;
            end
            WBL_RegWrite <= WB_we;
            WBL_RD       <= MW_RD;
            WBL_data     <= WB_data;
        end
    end

    always_comb begin
        RS_data = (RS_addr == '0) ? '0 : regs[RS_addr];
        RT_data = (RT_addr == '0) ? '0 : regs[RT_addr];
`ifdef REGFILE_BYPASS_EN
        // WB_we already excludes R0, so index 0 keeps reading zero.
        if (WB_we && (RS_addr == MW_RD)) begin
            RS_data = WB_data;
        end
        if (WB_we && (RT_addr == MW_RD)) begin
            RT_data = WB_data;
        end
`endif
    end
endmodule
